// File: rtl/iob_axi_pkg.sv
// Shared AXI burst/response constants and FSM state encoding for the memory responder.
package iob_axi_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WDATA = 2'b01,
      ST_WRESP = 2'b10,
      ST_RDATA = 2'b11
   } axi_state_t;

   // WRAP is served as a linear increment; only FIXED holds the address.
   function automatic logic burst_advances(input logic [1:0] burst);
      return (burst != AXI_BURST_FIXED);
   endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register only updates on a read access, so it holds its data while i_en is low.
module iob_ram_sp_be #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   input  logic [DATA_W/8-1:0]   i_we,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [DATA_W-1:0]     i_wdata,
   output logic [DATA_W-1:0]     o_rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] r_rdata;

   // Byte-lane writes; array contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (i_en && i_we[i]) begin
            r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
         end
      end
   end

   // Registered read data, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_en && (i_we == '0)) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/iob_axi_mem_slave.sv
// AXI4 memory responder serving serialized INCR/FIXED bursts from a single-port RAM.
// Optional macro AXI_MEM_SLAVE_STALL_EN adds LFSR-driven random stalls on the handshakes.
module iob_axi_mem_slave
   import iob_axi_pkg::*;
#(
   parameter int          AXI_ID_W   = 1,
   parameter int          AXI_ADDR_W = 32,
   parameter int          AXI_DATA_W = 32,
   parameter int          MEM_ADDR_W = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AXI_ID_W-1:0]     s_axi_awid,
   input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
   input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [AXI_ID_W-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [AXI_ID_W-1:0]     s_axi_arid,
   input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [AXI_ID_W-1:0]     s_axi_rid,
   output logic [AXI_DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int B = $clog2(AXI_DATA_W / 8);

   axi_state_t                r_state;
   axi_state_t                w_state_nxt;
   logic                      r_last_was_read;
   logic [MEM_ADDR_W-1:0]     r_addr;
   logic [7:0]                r_len;
   logic [7:0]                r_cnt;
   logic [AXI_ID_W-1:0]       r_id;
   logic [1:0]                r_burst;
   logic                      r_bvalid;
   logic [1:0]                r_bresp;
   logic                      r_rvalid;
   logic                      r_rlast;
   logic                      r_rd_done;

   logic                      w_awready;
   logic                      w_arready;
   logic                      w_wready;
   logic                      w_aw_hs;
   logic                      w_ar_hs;
   logic                      w_w_hs;
   logic                      w_rd_en;
   logic                      w_stall;
   logic [AXI_DATA_W-1:0]     w_ram_rdata;
   logic [AXI_DATA_W/8-1:0]   w_ram_we;
   logic                      w_unused;

`ifdef AXI_MEM_SLAVE_STALL_EN
   logic [15:0] r_lfsr;

   // 16-bit Fibonacci LFSR, taps 16/14/13/11, stepping every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_stall = r_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   // Burst size and out-of-range address bits carry no meaning for this memory.
   assign w_unused = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr, LFSR_SEED};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and channel readies; a tie goes to whichever channel was not served last.
   always_comb begin
      w_state_nxt = r_state;
      w_awready   = 1'b0;
      w_arready   = 1'b0;
      w_wready    = 1'b0;
      if (rst || w_stall) begin
         w_state_nxt = r_state;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (s_axi_arvalid && (!s_axi_awvalid || !r_last_was_read)) begin
                  w_arready   = 1'b1;
                  w_state_nxt = ST_RDATA;
               end else if (s_axi_awvalid) begin
                  w_awready   = 1'b1;
                  w_state_nxt = ST_WDATA;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_WDATA: begin
               w_wready = 1'b1;
               if (s_axi_wvalid && s_axi_wlast) begin
                  w_state_nxt = ST_WRESP;
               end else begin
                  w_state_nxt = ST_WDATA;
               end
            end
            ST_WRESP: begin
               if (r_bvalid && s_axi_bready) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_WRESP;
               end
            end
            ST_RDATA: begin
               if (r_rvalid && s_axi_rready && r_rlast) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_RDATA;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign w_aw_hs = w_awready && s_axi_awvalid;
   assign w_ar_hs = w_arready && s_axi_arvalid;
   assign w_w_hs  = w_wready && s_axi_wvalid;

   // A read is issued only when the output slot is empty or being drained this cycle.
   assign w_rd_en = (r_state == ST_RDATA) && !r_rd_done && (!r_rvalid || s_axi_rready) && !w_stall;

   // Burst context, beat counter and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_was_read <= 1'b0;
         r_addr          <= '0;
         r_len           <= 8'd0;
         r_cnt           <= 8'd0;
         r_id            <= '0;
         r_burst         <= 2'b00;
         r_rd_done       <= 1'b0;
         r_bvalid        <= 1'b0;
         r_bresp         <= 2'b00;
         r_rvalid        <= 1'b0;
         r_rlast         <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_last_was_read <= 1'b1;
            r_addr          <= s_axi_araddr[MEM_ADDR_W+B-1:B];
            r_len           <= s_axi_arlen;
            r_id            <= s_axi_arid;
            r_burst         <= s_axi_arburst;
            r_cnt           <= 8'd0;
            r_rd_done       <= 1'b0;
         end else if (w_aw_hs) begin
            r_last_was_read <= 1'b0;
            r_addr          <= s_axi_awaddr[MEM_ADDR_W+B-1:B];
            r_len           <= s_axi_awlen;
            r_id            <= s_axi_awid;
            r_burst         <= s_axi_awburst;
            r_cnt           <= 8'd0;
         end else if (w_w_hs || w_rd_en) begin
            r_cnt <= r_cnt + 8'd1;
            if (burst_advances(r_burst)) begin
               r_addr <= r_addr + MEM_ADDR_W'(1);
            end
            if (w_rd_en) begin
               r_rd_done <= (r_cnt == r_len);
            end
         end

         if (w_w_hs && s_axi_wlast) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (r_cnt == r_len) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
         end else if (r_bvalid && s_axi_bready) begin
            r_bvalid <= 1'b0;
         end

         if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rlast  <= (r_cnt == r_len);
         end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   assign w_ram_we = w_w_hs ? s_axi_wstrb : '0;

   iob_ram_sp_be #(
      .DATA_W (AXI_DATA_W),
      .ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_w_hs || w_rd_en),
      .i_we    (w_ram_we),
      .i_addr  (r_addr),
      .i_wdata (s_axi_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign s_axi_awready = w_awready;
   assign s_axi_arready = w_arready;
   assign s_axi_wready  = w_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_bid     = r_id;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rid     = r_id;
   assign s_axi_rdata   = w_ram_rdata;
   assign s_axi_rresp   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_iob_axi_mem_slave.sv
// Scoreboard bench for iob_axi_mem_slave: a word-array memory model predicts B and R traffic.
module tb_iob_axi_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;

   always #5 clk = ~clk;

   iob_axi_mem_slave dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
      .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   int          checks = 0;
   int          errors = 0;
   int          rr_mode = 0;
   int          r_beats = 0;
   logic [35:0] sb_r[$];
   logic [2:0]  sb_b[$];
   logic [31:0] mem_m[int];
   logic [31:0] wd[256];
   logic [3:0]  ws[256];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'h0000_FFFF);
   endfunction

   function automatic int beat_word(input logic [31:0] a, input logic [1:0] burst, input int i);
      return (burst == 2'b00) ? widx(a) : ((widx(a) + i) % 65536);
   endfunction

   task automatic model_write(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                              input logic [1:0] burst, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         int w;
         logic [31:0] t;
         w = beat_word(a, burst, i);
         t = mem_m.exists(w) ? mem_m[w] : 32'hxxxx_xxxx;
         for (int k = 0; k < 4; k++) if (ws[i][k]) t[k*8 +: 8] = wd[i][k*8 +: 8];
         mem_m[w] = t;
      end
      sb_b.push_back({id, (nbeats == int'(len) + 1) ? 2'b00 : 2'b10});
   endtask

   task automatic model_read(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [1:0] burst);
      for (int i = 0; i <= int'(len); i++) begin
         sb_r.push_back({id, mem_m[beat_word(a, burst, i)], 2'b00, (i == int'(len))});
      end
   endtask

   task automatic w_send(input int nbeats, input int gaps);
      for (int i = 0; i < nbeats; i++) begin
         int n = 0;
         if (gaps != 0) begin
            wvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
         @(negedge clk);
         while (!wready && n < 100) begin @(negedge clk); n++; end
         if (!wready) chk("w_handshake_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic wr_burst(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input int gaps);
      int n = 0;
      model_write(id, a, len, burst, nbeats);
      awid = id; awaddr = a; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
      @(negedge clk);
      while (!awready && n < 100) begin @(negedge clk); n++; end
      if (!awready) chk("aw_handshake_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      w_send(nbeats, gaps);
   endtask

   task automatic rd_burst(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input int lat_chk, input int first_chk);
      int n = 0;
      model_read(id, a, len, burst);
      arid = id; araddr = a; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
      @(negedge clk);
      if (first_chk != 0) begin
         chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
         chk("rst_mid_arready", 64'(arready), 64'd1);
      end
      while (!arready && n < 100) begin @(negedge clk); n++; end
      if (!arready) chk("ar_handshake_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (lat_chk != 0) begin
         @(negedge clk); chk("r_latency_t1", 64'(rvalid), 64'd0);
         @(negedge clk); chk("r_latency_t2", 64'(rvalid), 64'd1);
         for (int i = 1; i <= int'(len); i++) begin
            @(negedge clk); chk("r_stream", 64'(rvalid), 64'd1);
         end
         @(negedge clk); chk("r_drop_after_last", 64'(rvalid), 64'd0);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb_r.size() != 0 || sb_b.size() != 0) && n < 2000) begin @(negedge clk); n++; end
      if (sb_r.size() != 0 || sb_b.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   // Ready generator for the R and B channels.
   initial begin
      rready = 1'b1; bready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            0: begin rready = 1'b1; bready = 1'b1; end
            1: begin rready = ~rready; bready = 1'b1; end
            default: begin rready = 1'($urandom_range(0, 1)); bready = 1'($urandom_range(0, 1)); end
         endcase
      end
   end

   // Monitor: pops the scoreboard on every B/R handshake and checks R hold under back-pressure.
   initial begin
      logic        hold_vld;
      logic [35:0] hold, exp_r;
      logic [2:0]  exp_b;
      hold_vld = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_vld = 1'b0;
         end else begin
            if (bvalid && bready) begin
               if (sb_b.size() == 0) chk("b_unexpected", 64'({bid, bresp}), 64'hFFFF);
               else begin exp_b = sb_b.pop_front(); chk("b_resp", 64'({bid, bresp}), 64'(exp_b)); end
            end
            if (rvalid) begin
               if (hold_vld) chk("r_hold_stable", 64'({rid, rdata, rresp, rlast}), 64'(hold));
               if (rready) begin
                  if (sb_r.size() == 0) chk("r_unexpected", 64'({rid, rdata, rresp, rlast}), 64'hF_FFFF_FFFF_FFFF);
                  else begin exp_r = sb_r.pop_front(); chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(exp_r)); end
                  r_beats++;
                  hold_vld = 1'b0;
               end else begin
                  hold_vld = 1'b1;
                  hold = {rid, rdata, rresp, rlast};
               end
            end else begin
               hold_vld = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int base;
      int n;
      rst = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_bvalid", 64'({bvalid, bresp, bid}), 64'd0);
      chk("rst_rvalid", 64'({rvalid, rlast, rresp, rid}), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      @(posedge clk); #1;

      // Fill words 0..255 with one maximal INCR burst.
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b0, 32'h0, 8'd255, 2'b01, 256, 0); wait_done();

      // Single write then read at 0x100.
      wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
      wr_burst(1'b0, 32'h100, 8'd0, 2'b01, 1, 0); wait_done();
      rd_burst(1'b0, 32'h100, 8'd0, 2'b01, 1, 0); wait_done();

      // INCR 8-beat burst at 0x40.
      for (int i = 0; i < 8; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
      wr_burst(1'b1, 32'h40, 8'd7, 2'b01, 8, 0); wait_done();
      rd_burst(1'b1, 32'h40, 8'd7, 2'b01, 1, 0); wait_done();

      // Byte strobes.
      wd[0] = 32'h1122_3344; ws[0] = 4'hF;
      wr_burst(1'b0, 32'h200, 8'd0, 2'b01, 1, 0); wait_done();
      wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5;
      wr_burst(1'b0, 32'h200, 8'd0, 2'b01, 1, 0); wait_done();
      rd_burst(1'b0, 32'h200, 8'd0, 2'b01, 0, 0); wait_done();

      // Early wlast gives SLVERR, the next burst is OKAY.
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b1, 32'h300, 8'd3, 2'b01, 2, 0); wait_done();
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b0, 32'h300, 8'd3, 2'b01, 4, 0); wait_done();
      rd_burst(1'b0, 32'h300, 8'd3, 2'b01, 0, 0); wait_done();

      // FIXED bursts and wrap of the word address past the top of the RAM (with aliased upper bits).
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b1, 32'h180, 8'd3, 2'b00, 4, 0); wait_done();
      rd_burst(1'b1, 32'h180, 8'd2, 2'b00, 0, 0); wait_done();
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(1'b0, 32'h5003_FFF8, 8'd3, 2'b01, 4, 0); wait_done();
      rd_burst(1'b0, 32'h0003_FFF8, 8'd3, 2'b10, 0, 0); wait_done();

      // Arbitration from reset with both address channels pending; read is toggled by rready.
      rst = 1'b1;
      wd[0] = $urandom; ws[0] = 4'hF;
      model_read(1'b0, 32'h80, 8'd3, 2'b01);
      model_write(1'b1, 32'hC0, 8'd0, 2'b01, 1);
      arid = 1'b0; araddr = 32'h80; arlen = 8'd3; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
      awid = 1'b1; awaddr = 32'hC0; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
      @(negedge clk);
      chk("rst_arready_held", 64'({awready, arready}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; rr_mode = 1;
      @(negedge clk);
      chk("arb_first_read", 64'({awready, arready}), 64'b01);
      @(posedge clk); #1 arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!awready && n < 200) begin @(negedge clk); n++; end
      chk("arb_write_after_read", 64'(awready), 64'd1);
      chk("arb_read_done_first", 64'(sb_r.size()), 64'd0);
      @(posedge clk); #1 awvalid = 1'b0;
      w_send(1, 0); wait_done();
      rr_mode = 0;

      // Reset during beat 3 of an 8-beat read.
      base = r_beats;
      rd_burst(1'b1, 32'h20, 8'd7, 2'b01, 0, 0);
      n = 0;
      while (r_beats != base + 2 && n < 100) begin @(posedge clk); #1; n++; end
      chk("rst_mid_reach_beat3", 64'(r_beats - base), 64'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      sb_r.delete();
      rst = 1'b0;
      rd_burst(1'b0, 32'h60, 8'd7, 2'b01, 0, 1); wait_done();

      // Randomized mix under random back-pressure.
      rr_mode = 2;
      for (int t = 0; t < 40; t++) begin
         logic [7:0]  len;
         logic [1:0]  burst;
         logic [31:0] a;
         int          nb;
         len   = 8'($urandom_range(0, 15));
         burst = 2'($urandom_range(0, 2));
         a     = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 200)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            nb = int'(len) + 1;
            if (len != 8'd0 && $urandom_range(0, 4) == 0) nb = $urandom_range(1, int'(len));
            for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
            wr_burst(1'($urandom_range(0, 1)), a, len, burst, nb, 1);
         end else begin
            rd_burst(1'($urandom_range(0, 1)), a, len, burst, 0, 0);
         end
         wait_done();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
